// File: rtl/embedding_dual_if.sv
// Bundle of signals between the embedding lookup, its controller and the
// two weight_store read ports.
interface embedding_dual_if #(
  parameter int DIM    = 128,
  parameter int ID_W   = 8,
  parameter int ADDR_W = 16
);
  localparam int IDX_W = $clog2(DIM);

  logic                start_i;
  logic [ID_W-1:0]     token_id_i;
  logic [ID_W-1:0]     position_i;
  logic                mode_i;
  logic [5:0]          wa_sel_o;
  logic [ADDR_W-1:0]   wa_addr_o;
  logic [7:0]          wa_data_i;
  logic [5:0]          wb_sel_o;
  logic [ADDR_W-1:0]   wb_addr_o;
  logic [7:0]          wb_data_i;
  logic [DIM*8-1:0]    embed_o;
  logic                elem_valid_o;
  logic [IDX_W-1:0]    elem_idx_o;
  logic [7:0]          elem_data_o;
  logic                busy_o;
  logic                done_o;
  logic                range_err_o;

  // Controller / memory side: drives requests and read data.
  modport master (
    output start_i, token_id_i, position_i, mode_i, wa_data_i, wb_data_i,
    input  wa_sel_o, wa_addr_o, wb_sel_o, wb_addr_o, embed_o, elem_valid_o,
    input  elem_idx_o, elem_data_o, busy_o, done_o, range_err_o
  );

  // Lookup engine side.
  modport slave (
    input  start_i, token_id_i, position_i, mode_i, wa_data_i, wb_data_i,
    output wa_sel_o, wa_addr_o, wb_sel_o, wb_addr_o, embed_o, elem_valid_o,
    output elem_idx_o, elem_data_o, busy_o, done_o, range_err_o
  );
endinterface

// File: rtl/embedding_dual.sv
// Dual-port token + position embedding lookup. Token and position rows are
// read in parallel, one element per cycle, combined (halve or saturate) and
// streamed into the DIM-element int8 result vector.
module embedding_dual #(
  parameter int DIM     = 128,
  parameter int VOCAB   = 256,
  parameter int CTX     = 256,
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 16,
  parameter int TOK_SEL = 0,
  parameter int POS_SEL = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  embedding_dual_if.slave bus
);
  localparam int IDX_W = $clog2(DIM);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  idx_r;
  logic              mode_r;

  logic              range_s;
  logic [ADDR_W-1:0] tok_base_s;
  logic [ADDR_W-1:0] pos_base_s;
  logic [IDX_W-1:0]  elem_s;
  logic [7:0]        value_s;

  // Signed 9-bit sum, then either arithmetic halve or clamp to int8.
  function automatic logic [7:0] combine(input logic [7:0] a, input logic [7:0] b,
                                         input logic sat);
    logic signed [8:0] s;
    s = $signed({a[7], a}) + $signed({b[7], b});
    if (sat) begin
      if (s > 9'sd127) begin
        return 8'h7F;
      end else if (s < -9'sd128) begin
        return 8'h80;
      end else begin
        return s[7:0];
      end
    end else begin
      return s[8:1];
    end
  endfunction

  assign range_s    = (32'(bus.token_id_i) >= 32'(VOCAB)) ||
                      (32'(bus.position_i) >= 32'(CTX));
  assign tok_base_s = ADDR_W'(bus.token_id_i) * ADDR_W'(DIM);
  assign pos_base_s = ADDR_W'(bus.position_i) * ADDR_W'(DIM);
  // Read data arriving now belongs to the address issued one step earlier.
  assign elem_s     = IDX_W'(idx_r - CNT_W'(1));
  // Out-of-range lookups never read memory, so their elements are forced to 0.
  assign value_s    = bus.range_err_o ? 8'h00 : combine(bus.wa_data_i, bus.wb_data_i, mode_r);

  // Lookup FSM: address issue, element combine/write and status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r          <= IDLE;
      idx_r            <= '0;
      mode_r           <= 1'b0;
      bus.wa_sel_o     <= 6'd0;
      bus.wb_sel_o     <= 6'd0;
      bus.wa_addr_o    <= '0;
      bus.wb_addr_o    <= '0;
      bus.embed_o      <= '0;
      bus.elem_valid_o <= 1'b0;
      bus.elem_idx_o   <= '0;
      bus.elem_data_o  <= 8'h00;
      bus.busy_o       <= 1'b0;
      bus.done_o       <= 1'b0;
      bus.range_err_o  <= 1'b0;
    end else begin
      bus.wa_sel_o     <= 6'(TOK_SEL);
      bus.wb_sel_o     <= 6'(POS_SEL);
      bus.elem_valid_o <= 1'b0;
      bus.done_o       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start_i) begin
            mode_r          <= bus.mode_i;
            bus.range_err_o <= range_s;
            bus.busy_o      <= 1'b1;
            idx_r           <= '0;
            state_r         <= READ;
            bus.wa_addr_o   <= range_s ? '0 : tok_base_s;
            bus.wb_addr_o   <= range_s ? '0 : pos_base_s;
          end
        end
        READ: begin
          // Next row element; addresses stay at 0 for a range error.
          if ((idx_r < CNT_W'(DIM - 1)) && !bus.range_err_o) begin
            bus.wa_addr_o <= bus.wa_addr_o + ADDR_W'(1);
            bus.wb_addr_o <= bus.wb_addr_o + ADDR_W'(1);
          end
          if (idx_r != '0) begin
            bus.embed_o[{elem_s, 3'b000} +: 8] <= value_s;
            bus.elem_valid_o <= 1'b1;
            bus.elem_idx_o   <= elem_s;
            bus.elem_data_o  <= value_s;
          end
          if (idx_r == CNT_W'(DIM)) begin
            state_r     <= IDLE;
            bus.busy_o  <= 1'b0;
            bus.done_o  <= 1'b1;
          end else begin
            idx_r <= idx_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          idx_r      <= '0;
          bus.busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_embedding_dual.sv
// Directed bench for embedding_dual: main instance with VOCAB=256 and a second
// instance with VOCAB=200 for the out-of-range case. Both share one memory image.
module tb_embedding_dual;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  embedding_dual_if #(.DIM(128), .ID_W(8), .ADDR_W(16)) bus ();
  embedding_dual_if #(.DIM(128), .ID_W(8), .ADDR_W(16)) bus2 ();

  embedding_dual #(.DIM(128), .VOCAB(256), .CTX(256)) dut  (.clk_i(clk), .rst_i(rst), .bus(bus));
  embedding_dual #(.DIM(128), .VOCAB(200), .CTX(256)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  logic [7:0] tok_mem [0:32767];
  logic [7:0] pos_mem [0:32767];

  // Weight store model: one-cycle read latency on both ports of both instances.
  always @(posedge clk) begin
    bus.wa_data_i  <= tok_mem[bus.wa_addr_o[14:0]];
    bus.wb_data_i  <= pos_mem[bus.wb_addr_o[14:0]];
    bus2.wa_data_i <= tok_mem[bus2.wa_addr_o[14:0]];
    bus2.wb_data_i <= pos_mem[bus2.wb_addr_o[14:0]];
  end

  int errors = 0;
  int checks = 0;

  logic          sel2 = 1'b0;
  logic          m_valid, m_done, m_busy, m_err;
  logic [6:0]    m_idx;
  logic [7:0]    m_data;
  logic [15:0]   m_wa, m_wb;
  logic [5:0]    m_was, m_wbs;
  logic [1023:0] m_embed;

  // Observe whichever instance the current scenario is driving.
  always_comb begin
    if (sel2) begin
      m_valid = bus2.elem_valid_o; m_done = bus2.done_o; m_busy = bus2.busy_o;
      m_err = bus2.range_err_o; m_idx = bus2.elem_idx_o; m_data = bus2.elem_data_o;
      m_wa = bus2.wa_addr_o; m_wb = bus2.wb_addr_o; m_was = bus2.wa_sel_o;
      m_wbs = bus2.wb_sel_o; m_embed = bus2.embed_o;
    end else begin
      m_valid = bus.elem_valid_o; m_done = bus.done_o; m_busy = bus.busy_o;
      m_err = bus.range_err_o; m_idx = bus.elem_idx_o; m_data = bus.elem_data_o;
      m_wa = bus.wa_addr_o; m_wb = bus.wb_addr_o; m_was = bus.wa_sel_o;
      m_wbs = bus.wb_sel_o; m_embed = bus.embed_o;
    end
  end

  logic [7:0]  got [0:127];
  logic [15:0] wa_tr [0:199];
  logic [15:0] wb_tr [0:199];
  int          n_strobe, done_cyc, last_c;
  logic        seq_ok, sel_ok, err_c0, busy_c0, done_busy;

  task automatic set_inputs(input logic st, input logic [7:0] tok, input logic [7:0] pos,
                            input logic md);
    if (sel2) begin
      bus2.start_i = st; bus2.token_id_i = tok; bus2.position_i = pos; bus2.mode_i = md;
    end else begin
      bus.start_i = st; bus.token_id_i = tok; bus.position_i = pos; bus.mode_i = md;
    end
  endtask

  // Call at a negedge; the following posedge is the start edge.
  task automatic start_pulse(input logic [7:0] tok, input logic [7:0] pos, input logic md);
    set_inputs(1'b1, tok, pos, md);
    @(posedge clk);
    #1;
    set_inputs(1'b0, tok, pos, md);
  endtask

  // Sample once per cycle (c = 0 right after the start edge) until done or 200 cycles.
  task automatic collect(input int poke_cyc);
    n_strobe = 0; seq_ok = 1'b1; sel_ok = 1'b1; done_cyc = -1; last_c = -1;
    err_c0 = 1'b0; busy_c0 = 1'b0; done_busy = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == poke_cyc) set_inputs(1'b1, 8'd7, 8'd7, 1'b1);
      else if (c == poke_cyc + 1) set_inputs(1'b0, 8'd7, 8'd7, 1'b1);
      if (c == 0) begin err_c0 = m_err; busy_c0 = m_busy; end
      wa_tr[c] = m_wa;
      wb_tr[c] = m_wb;
      if (m_was !== 6'd0 || m_wbs !== 6'd1) sel_ok = 1'b0;
      if (m_valid === 1'b1) begin
        if (m_idx !== 7'(n_strobe)) seq_ok = 1'b0;
        if (n_strobe == 0 && c != 2) seq_ok = 1'b0;
        if (n_strobe > 0 && last_c != c - 1) seq_ok = 1'b0;
        if (n_strobe < 128) got[n_strobe] = m_data;
        n_strobe++;
        last_c = c;
      end
      if (m_done === 1'b1) begin
        done_cyc = c; done_busy = m_busy;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_busy, m_done, m_valid, m_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_status: got %b want 0000", {m_busy, m_done, m_valid, m_err});
    end
    checks++;
    if (m_embed !== 1024'd0) begin errors++; $display("FAIL reset_embed: got nonzero want 0"); end
    checks++;
    if ({m_wa, m_wb} !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h %h want 0", m_wa, m_wb); end
    checks++;
    if ({m_was, m_wbs, m_idx, m_data} !== 27'd0) begin
      errors++; $display("FAIL reset_sel_elem: got %h %h %h %h want 0", m_was, m_wbs, m_idx, m_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] exp_b;
    exp_b = 8'h0B;
    sel2 = 1'b0;
    @(negedge clk);
    start_pulse(8'd5, 8'd3, 1'b0);
    collect(-10);
    checks++;
    if (busy_c0 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_c0); end
    checks++;
    if (done_cyc != 129) begin errors++; $display("FAIL basic_latency: got %0d want 129", done_cyc); end
    checks++;
    if (done_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", done_busy); end
    checks++;
    if (n_strobe != 128 || seq_ok !== 1'b1) begin
      errors++; $display("FAIL basic_strobes: got %0d seq %b want 128 seq 1", n_strobe, seq_ok);
    end
    for (int e = 0; e < 128; e++) begin
      checks++;
      if (got[e] !== exp_b) begin errors++; $display("FAIL basic_elem[%0d]: got %h want %h", e, got[e], exp_b); end
    end
    checks++;
    if (m_embed !== {128{exp_b}}) begin errors++; $display("FAIL basic_embed: got %h want all 0b", m_embed[63:0]); end
  endtask

  task automatic test_saturate;
    logic [7:0] row [0:3];
    logic       md  [0:3];
    logic [7:0] exp [0:3];
    row[0] = 8'd7; md[0] = 1'b1; exp[0] = 8'h7F;
    row[1] = 8'd9; md[1] = 1'b1; exp[1] = 8'h80;
    row[2] = 8'd7; md[2] = 1'b0; exp[2] = 8'h70;
    row[3] = 8'd9; md[3] = 1'b0; exp[3] = 8'h90;
    sel2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start_pulse(row[k], row[k], md[k]);
      collect(-10);
      checks++;
      if (got[0] !== exp[k] || got[127] !== exp[k]) begin
        errors++; $display("FAIL sat_elem[%0d]: got %h/%h want %h", k, got[0], got[127], exp[k]);
      end
      checks++;
      if (m_embed !== {128{exp[k]}}) begin
        errors++; $display("FAIL sat_embed[%0d]: got %h want all %h", k, m_embed[63:0], exp[k]);
      end
    end
  endtask

  task automatic test_addr_trace;
    logic [7:0] exp_e;
    sel2 = 1'b0;
    @(negedge clk);
    start_pulse(8'd255, 8'd0, 1'b1);
    collect(-10);
    for (int c = 0; c < 128; c++) begin
      checks++;
      if (wa_tr[c] !== 16'(32640 + c) || wb_tr[c] !== 16'(c)) begin
        errors++; $display("FAIL addr_trace[%0d]: got %0d %0d want %0d %0d", c, wa_tr[c], wb_tr[c], 32640 + c, c);
      end
    end
    checks++;
    if (sel_ok !== 1'b1) begin errors++; $display("FAIL addr_sel: got bad select want 0/1"); end
    for (int e = 0; e < 128; e++) begin
      exp_e = (e == 127) ? 8'h7F : 8'(e + 1);
      checks++;
      if (got[e] !== exp_e) begin errors++; $display("FAIL addr_elem[%0d]: got %h want %h", e, got[e], exp_e); end
    end
  endtask

  task automatic test_range;
    sel2 = 1'b1;
    @(negedge clk);
    start_pulse(8'd5, 8'd3, 1'b0);
    collect(-10);
    checks++;
    if (m_embed !== {128{8'h0B}}) begin errors++; $display("FAIL range_pre_embed: got %h want all 0b", m_embed[63:0]); end
    @(negedge clk);
    start_pulse(8'd200, 8'd3, 1'b1);
    collect(-10);
    checks++;
    if (err_c0 !== 1'b1 || m_err !== 1'b1) begin
      errors++; $display("FAIL range_flag: got %b/%b want 1/1", err_c0, m_err);
    end
    checks++;
    if (done_cyc != 129 || n_strobe != 128 || seq_ok !== 1'b1) begin
      errors++; $display("FAIL range_run: got done %0d strobes %0d seq %b want 129 128 1", done_cyc, n_strobe, seq_ok);
    end
    for (int c = 0; c < 130; c++) begin
      checks++;
      if (wa_tr[c] !== 16'd0 || wb_tr[c] !== 16'd0) begin
        errors++; $display("FAIL range_addr[%0d]: got %0d %0d want 0 0", c, wa_tr[c], wb_tr[c]);
      end
    end
    checks++;
    if (m_embed !== 1024'd0 || got[0] !== 8'h00 || got[127] !== 8'h00) begin
      errors++; $display("FAIL range_embed: got %h %h %h want 0", m_embed[63:0], got[0], got[127]);
    end
    @(negedge clk);
    start_pulse(8'd5, 8'd3, 1'b0);
    collect(-10);
    checks++;
    if (err_c0 !== 1'b0) begin errors++; $display("FAIL range_clear: got %b want 0", err_c0); end
    sel2 = 1'b0;
  endtask

  task automatic test_back_to_back;
    sel2 = 1'b0;
    @(negedge clk);
    start_pulse(8'd5, 8'd3, 1'b0);
    collect(50);
    checks++;
    if (done_cyc != 129) begin errors++; $display("FAIL b2b_first_latency: got %0d want 129", done_cyc); end
    checks++;
    if (got[0] !== 8'h0B || got[127] !== 8'h0B || m_embed !== {128{8'h0B}}) begin
      errors++; $display("FAIL b2b_busy_start_ignored: got %h %h want 0b", got[0], got[127]);
    end
    // Already at the negedge of the done cycle: start with zero gap.
    start_pulse(8'd7, 8'd7, 1'b1);
    collect(-10);
    checks++;
    if (done_cyc != 129) begin errors++; $display("FAIL b2b_second_latency: got %0d want 129", done_cyc); end
    checks++;
    if (m_embed !== {128{8'h7F}}) begin errors++; $display("FAIL b2b_second_embed: got %h want all 7f", m_embed[63:0]); end
  endtask

  task automatic test_reset_mid;
    int done_seen;
    sel2 = 1'b0;
    @(negedge clk);
    start_pulse(8'd9, 8'd9, 1'b1);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_busy, m_done, m_valid, m_err, m_idx, m_data} !== 19'd0) begin
      errors++; $display("FAIL rst_mid_status: got %b %b %b %b %h %h want 0", m_busy, m_done, m_valid, m_err, m_idx, m_data);
    end
    checks++;
    if (m_embed !== 1024'd0 || {m_wa, m_wb, m_was, m_wbs} !== 44'd0) begin
      errors++; $display("FAIL rst_mid_regs: got %h %h %h want 0", m_embed[63:0], m_wa, m_wb);
    end
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (m_done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_seen); end
    start_pulse(8'd7, 8'd7, 1'b0);
    collect(-10);
    checks++;
    if (done_cyc != 129 || m_embed !== {128{8'h70}}) begin
      errors++; $display("FAIL rst_mid_restart: got done %0d elem %h want 129 70", done_cyc, m_embed[7:0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      tok_mem[i] = 8'h55;
      pos_mem[i] = 8'h33;
    end
    for (int j = 0; j < 128; j++) begin
      tok_mem[5 * 128 + j]   = 8'h10;
      pos_mem[3 * 128 + j]   = 8'h06;
      tok_mem[7 * 128 + j]   = 8'h70;
      pos_mem[7 * 128 + j]   = 8'h70;
      tok_mem[9 * 128 + j]   = 8'h90;
      pos_mem[9 * 128 + j]   = 8'h90;
      tok_mem[255 * 128 + j] = 8'(j);
      pos_mem[j]             = 8'h01;
    end
    bus.start_i = 1'b0;  bus.token_id_i = 8'd0;  bus.position_i = 8'd0;  bus.mode_i = 1'b0;
    bus2.start_i = 1'b0; bus2.token_id_i = 8'd0; bus2.position_i = 8'd0; bus2.mode_i = 1'b0;

    test_reset();
    test_basic();
    test_saturate();
    test_addr_trace();
    test_range();
    test_back_to_back();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
